// File: rtl/load_extend_pipe.sv
// Two-stage load-data aligner: stage 1 right-aligns the addressed byte/half/word,
// stage 2 holds the sign- or zero-extended result with its error flag and tag.
module load_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W = 5,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [TAG_W-1:0]  out_tag
);

  function automatic logic misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      2'b10:   r = (off != {OFF_W{1'b0}});
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] item,
                                               input logic [1:0] size, input logic sgn);
    logic [DATA_W-1:0] r;
    r = item;
    case (size)
      2'b00: for (int i = 8; i < DATA_W; i++) r[i] = sgn & item[7];
      2'b01: for (int i = 16; i < DATA_W; i++) r[i] = sgn & item[15];
      2'b10: r = item;
      default: r = {DATA_W{1'b0}};
    endcase
    return r;
  endfunction

  logic              s1_valid_r;
  logic [DATA_W-1:0] s1_item_r;
  logic [1:0]        s1_size_r;
  logic              s1_signed_r;
  logic              s1_err_r;
  logic [TAG_W-1:0]  s1_tag_r;

  logic              s2_valid_r;
  logic [DATA_W-1:0] s2_data_r;
  logic              s2_err_r;
  logic [TAG_W-1:0]  s2_tag_r;

  logic              s2_load_s;
  logic              s1_adv_s;
  logic              s1_open_s;
  logic              in_fire_s;
  logic [DATA_W-1:0] in_item_s;
  logic              in_err_s;
  logic [DATA_W-1:0] ext_data_s;

  assign s2_load_s = !s2_valid_r || out_ready;
  assign s1_adv_s  = s1_valid_r && s2_load_s;
  assign s1_open_s = !s1_valid_r || s1_adv_s;
  // resetn gating keeps in_ready low while the block is held in reset
  assign in_ready  = resetn && !flush && s1_open_s;
  assign in_fire_s = in_valid && in_ready;

  // Item alignment for stage 1 and extension for stage 2
  always_comb begin
    in_item_s = in_data >> {in_off, 3'b000};
    in_err_s  = misaligned(in_size, in_off);
    if (s1_err_r) begin
      ext_data_s = {DATA_W{1'b0}};
    end else begin
      ext_data_s = extend(s1_item_r, s1_size_r, s1_signed_r);
    end
  end

  // Stage valid bits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      if (s2_load_s) s2_valid_r <= s1_valid_r;
      if (s1_open_s) s1_valid_r <= in_valid;
    end
  end

  // Stage 1 payload
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_item_r   <= {DATA_W{1'b0}};
      s1_size_r   <= 2'b00;
      s1_signed_r <= 1'b0;
      s1_err_r    <= 1'b0;
      s1_tag_r    <= {TAG_W{1'b0}};
    end else if (in_fire_s) begin
      s1_item_r   <= in_item_s;
      s1_size_r   <= in_size;
      s1_signed_r <= in_signed;
      s1_err_r    <= in_err_s;
      s1_tag_r    <= in_tag;
    end
  end

  // Stage 2 payload, which drives the outputs directly
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_data_r <= {DATA_W{1'b0}};
      s2_err_r  <= 1'b0;
      s2_tag_r  <= {TAG_W{1'b0}};
    end else if (s1_adv_s) begin
      s2_data_r <= ext_data_s;
      s2_err_r  <= s1_err_r;
      s2_tag_r  <= s1_tag_r;
    end
  end

  assign out_valid = s2_valid_r;
  assign out_data  = s2_data_r;
  assign out_err   = s2_err_r;
  assign out_tag   = s2_tag_r;

endmodule

// File: tb/tb_load_extend_pipe.sv
// Scoreboard bench for load_extend_pipe: expected beats are queued at input
// acceptance and compared in order at each output handshake.
module tb_load_extend_pipe;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic [1:0]  in_off = 2'd0;
  logic [1:0]  in_size = 2'd0;
  logic        in_signed = 1'b0;
  logic [4:0]  in_tag = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_err;
  logic [4:0]  out_tag;

  load_extend_pipe #(.DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_off(in_off),
    .in_size(in_size), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [4:0]  tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          rand_bp = 1'b0;
  bit          stall_seen = 1'b0;
  logic [31:0] stall_data;
  logic        stall_err;
  logic [4:0]  stall_tag;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] d, input logic [1:0] off,
                                 input logic [1:0] size, input logic sgn, input logic [4:0] tag);
    exp_t e;
    logic [7:0]  b;
    logic [15:0] h;
    e.tag = tag;
    e.err = 1'b0;
    e.data = 32'd0;
    case (size)
      2'd0: begin
        b = d[off*8 +: 8];
        e.data = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      end
      2'd1: begin
        if (off[0]) e.err = 1'b1;
        else begin
          h = d[off*8 +: 16];
          e.data = sgn ? {{16{h[15]}}, h} : {16'd0, h};
        end
      end
      2'd2: begin
        if (off != 2'd0) e.err = 1'b1;
        else e.data = d;
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Output monitor: hold stability, in-order compare, queue push on acceptance
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (out_valid && stall_seen) begin
        check_eq("hold_data", out_data, stall_data);
        check_eq("hold_err", out_err, stall_err);
        check_eq("hold_tag", out_tag, stall_tag);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("out_without_pending", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check_eq("sb_data", out_data, e.data);
          check_eq("sb_err", out_err, e.err);
          check_eq("sb_tag", out_tag, e.tag);
        end
      end
      stall_seen = out_valid && !out_ready;
      stall_data = out_data;
      stall_err = out_err;
      stall_tag = out_tag;
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  // Random consumer backpressure
  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic present(input logic [31:0] d, input logic [1:0] off, input logic [1:0] size,
                         input logic sgn, input logic [4:0] tag, input exp_t e);
    in_valid = 1'b1;
    in_data = d;
    in_off = off;
    in_size = size;
    in_signed = sgn;
    in_tag = tag;
    cur_exp = e;
  endtask

  task automatic wait_accept();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check_eq("accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic send_x(input logic [31:0] d, input logic [1:0] off, input logic [1:0] size,
                        input logic sgn, input logic [4:0] tag,
                        input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    e.data = exp_data;
    e.err = exp_err;
    e.tag = tag;
    present(d, off, size, sgn, tag, e);
    wait_accept();
  endtask

  task automatic send_m(input logic [31:0] d, input logic [1:0] off, input logic [1:0] size,
                        input logic sgn, input logic [4:0] tag);
    present(d, off, size, sgn, tag, model(d, off, size, sgn, tag));
    wait_accept();
  endtask

  task automatic lat_check(input logic [31:0] exp_data, input logic [4:0] exp_tag);
    @(negedge clk);
    check_eq("lat_cycle1_valid", out_valid, 1'b0);
    @(negedge clk);
    check_eq("lat_cycle2_valid", out_valid, 1'b1);
    check_eq("lat_data", out_data, exp_data);
    check_eq("lat_tag", out_tag, exp_tag);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1 resetn = 1'b0;
    #11;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_err", out_err, 1'b0);
    check_eq("rst_out_tag", out_tag, 5'd0);
    #10 resetn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    // Signed byte with 2-cycle latency
    send_x(32'h12803456, 2'd2, 2'd0, 1'b1, 5'd7, 32'hFFFFFF80, 1'b0);
    in_valid = 1'b0;
    lat_check(32'hFFFFFF80, 5'd7);

    // Half-word zero/sign extension, then errors and a full word
    send_x(32'h80011234, 2'd2, 2'd1, 1'b0, 5'd3, 32'h00008001, 1'b0);
    send_x(32'h80011234, 2'd2, 2'd1, 1'b1, 5'd4, 32'hFFFF8001, 1'b0);
    send_x(32'hDEADBEEF, 2'd1, 2'd1, 1'b1, 5'd8, 32'd0, 1'b1);
    send_x(32'hDEADBEEF, 2'd2, 2'd2, 1'b0, 5'd9, 32'd0, 1'b1);
    send_x(32'hDEADBEEF, 2'd0, 2'd3, 1'b0, 5'd10, 32'd0, 1'b1);
    send_x(32'hCAFEF00D, 2'd0, 2'd2, 1'b1, 5'd11, 32'hCAFEF00D, 1'b0);
    in_valid = 1'b0;
    drain();

    // Backpressure: A and B accepted, C blocked while A holds
    out_ready = 1'b0;
    send_x(32'h000000A5, 2'd0, 2'd0, 1'b0, 5'd1, 32'h000000A5, 1'b0);
    send_x(32'h0000B600, 2'd1, 2'd0, 1'b1, 5'd2, 32'hFFFFFFB6, 1'b0);
    present(32'h00C70000, 2'd2, 2'd0, 1'b0, 5'd3, model(32'h00C70000, 2'd2, 2'd0, 1'b0, 5'd3));
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_in_ready", in_ready, 1'b0);
      check_eq("bp_out_valid", out_valid, 1'b1);
      check_eq("bp_out_data", out_data, 32'h000000A5);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    drain();

    // Flush with two in flight and a new beat offered
    send_m(32'h11223344, 2'd1, 2'd0, 1'b0, 5'd12);
    send_m(32'h55667788, 2'd0, 2'd1, 1'b1, 5'd13);
    present(32'h99AABBCC, 2'd3, 2'd0, 1'b1, 5'd14, model(32'h99AABBCC, 2'd3, 2'd0, 1'b1, 5'd14));
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_out_valid", out_valid, 1'b0);
    drain();

    // Asynchronous reset while stage 2 is full
    out_ready = 1'b0;
    send_m(32'h0BADCAFE, 2'd0, 2'd2, 1'b0, 5'd15);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("pre_reset_valid", out_valid, 1'b1);
    #2 resetn = 1'b0;
    sb.delete();
    #1;
    check_eq("async_rst_out_valid", out_valid, 1'b0);
    check_eq("async_rst_in_ready", in_ready, 1'b0);
    check_eq("async_rst_out_data", out_data, 32'd0);
    check_eq("async_rst_out_tag", out_tag, 5'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    out_ready = 1'b1;
    send_x(32'h00007F00, 2'd1, 2'd0, 1'b1, 5'd16, 32'h0000007F, 1'b0);
    in_valid = 1'b0;
    lat_check(32'h0000007F, 5'd16);
    drain();

    // Random traffic under random backpressure
    rand_bp = 1'b1;
    for (int n = 0; n < 150; n++) begin
      send_m($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    rand_bp = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
